// File: rtl/viterbi_code_sync_if.sv
// Code-stream bundle between the channel/encoder side and the symbol synchronizer.
// The master drives the raw code. The slave returns the sampled symbol, its strobe and the lock flags.
interface viterbi_code_sync_if #(
    parameter int unsigned WD_CODE = 2
);
    logic [WD_CODE-1:0] Code;
    logic [WD_CODE-1:0] CodeOut;
    logic               SymValid;
    logic               Active;
    logic               LockLost;

    modport master (
        output Code,
        input  CodeOut,
        input  SymValid,
        input  Active,
        input  LockLost
    );

    modport slave (
        input  Code,
        output CodeOut,
        output SymValid,
        output Active,
        output LockLost
    );
endinterface

// File: rtl/viterbi_code_sync.sv
// Mid-symbol sampler and lock generator in front of the Viterbi decoder.
// Optional phase re-centring on every code transition is enabled by defining SYNC_TRACK_EN.
module viterbi_code_sync #(
    parameter int unsigned WD_CODE    = 2,
    parameter int unsigned SYM_CYCLES = 8,
    parameter int unsigned IDLE_SYMS  = 16
) (
    input  logic                CLOCK,
    input  logic                Reset,
    viterbi_code_sync_if.slave  bus
);
    localparam int unsigned PW  = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
    localparam int unsigned ZW  = $clog2(IDLE_SYMS + 1);
    localparam int unsigned MID = SYM_CYCLES / 2;

    typedef enum logic [1:0] {
        IDLE,
        ALIGN,
        LOCK
    } state_t;

    state_t             state;
    logic [WD_CODE-1:0] code_q;
    logic [PW-1:0]      phase;
    logic [ZW-1:0]      zcnt;

    logic               code_nz_c;
    logic               at_mid_c;
    logic [PW-1:0]      phase_inc_c;

    assign code_nz_c   = |bus.Code;
    assign at_mid_c    = (phase == PW'(MID));
    assign phase_inc_c = (phase == PW'(SYM_CYCLES - 1)) ? '0 : phase + PW'(1);

    // Symbol timer, zero-run counter and registered outputs
    always_ff @(posedge CLOCK) begin
        if (!Reset) begin
            state        <= IDLE;
            code_q       <= '0;
            phase        <= '0;
            zcnt         <= '0;
            bus.CodeOut  <= '0;
            bus.SymValid <= 1'b0;
            bus.Active   <= 1'b0;
            bus.LockLost <= 1'b0;
        end else begin
            code_q       <= bus.Code;
            bus.SymValid <= 1'b0;
            bus.LockLost <= 1'b0;
            case (state)
                IDLE: begin
                    phase <= '0;
                    zcnt  <= '0;
                    // Only a zero-to-nonzero edge starts acquisition
                    if (!(|code_q) && code_nz_c) begin
                        state <= ALIGN;
                        phase <= PW'(1);
                    end
                end
                ALIGN: begin
                    phase <= phase_inc_c;
                    if (at_mid_c) begin
                        bus.CodeOut  <= bus.Code;
                        bus.SymValid <= 1'b1;
                        bus.Active   <= 1'b1;
                        zcnt         <= '0;
                        state        <= LOCK;
                    end
                end
                LOCK: begin
                    phase <= phase_inc_c;
`ifdef SYNC_TRACK_EN
                    if (bus.Code != code_q) begin
                        phase <= PW'(1);
                    end
`endif
                    if (at_mid_c) begin
                        if (code_nz_c) begin
                            zcnt         <= '0;
                            bus.CodeOut  <= bus.Code;
                            bus.SymValid <= 1'b1;
                        end else if (zcnt != ZW'(IDLE_SYMS - 1)) begin
                            zcnt         <= zcnt + ZW'(1);
                            bus.CodeOut  <= '0;
                            bus.SymValid <= 1'b1;
                        end else begin
                            // Long idle run: drop lock, hold the last CodeOut
                            bus.Active   <= 1'b0;
                            bus.LockLost <= 1'b1;
                            state        <= IDLE;
                            phase        <= '0;
                            zcnt         <= '0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_viterbi_code_sync.sv
// Scoreboard bench for viterbi_code_sync: a timeline model predicts sample instants and lock flags per cycle.
// It also covers the SYNC_TRACK_EN build, because the model and the drift checks follow the same macro.
module tb_viterbi_code_sync;
    localparam int SYM  = 8;
    localparam int MID  = SYM / 2;
    localparam int IDLE = 16;
`ifdef SYNC_TRACK_EN
    localparam bit TRACK = 1'b1;
`else
    localparam bit TRACK = 1'b0;
`endif

    typedef struct {
        int         t;
        logic [1:0] kind;   // {SymValid, LockLost}
    } ev_t;

    typedef struct {
        logic       act;
        logic [1:0] out;
    } cyc_t;

    logic CLOCK = 1'b0;
    logic Reset;
    always #5 CLOCK = ~CLOCK;

    viterbi_code_sync_if #(.WD_CODE(2)) bus ();

    viterbi_code_sync #(
        .WD_CODE    (2),
        .SYM_CYCLES (SYM),
        .IDLE_SYMS  (IDLE)
    ) dut (
        .CLOCK (CLOCK),
        .Reset (Reset),
        .bus   (bus)
    );

    int         tests = 0;
    int         fails = 0;
    int         gbase = 0;
    ev_t        evq[$];
    cyc_t       cycq[$];
    logic [1:0] obs[$];
    logic [1:0] seg[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int t);
        tests++;
        fails++;
        $display("FAIL %s at cycle %0d", name, t);
    endtask

    // Timeline model: start edge, then samples every SYM cycles (or MID after a transition when tracking)
    function automatic void model(input logic [1:0] c[$], input int base);
        logic [1:0] prev = 2'b00;
        logic [1:0] out  = 2'b00;
        bit         acq  = 1'b0;
        bit         act  = 1'b0;
        bit         was;
        int         nxt  = 0;
        int         zr   = 0;
        for (int t = 0; t < c.size(); t++) begin
            was = act;
            if (!acq) begin
                if (prev == 2'b00 && c[t] != 2'b00) begin
                    acq = 1'b1;
                    nxt = t + MID;
                end
            end else if (t == nxt) begin
                if (!act) begin
                    out = c[t]; act = 1'b1; zr = 0; nxt = t + SYM;
                    evq.push_back('{base + t, 2'b10});
                end else if (c[t] != 2'b00 || zr + 1 < IDLE) begin
                    zr  = (c[t] == 2'b00) ? zr + 1 : 0;
                    out = c[t]; nxt = t + SYM;
                    evq.push_back('{base + t, 2'b10});
                end else begin
                    act = 1'b0; acq = 1'b0; zr = 0;
                    evq.push_back('{base + t, 2'b01});
                end
            end
            if (TRACK && was && acq && c[t] != prev) nxt = t + MID;
            cycq.push_back('{act, out});
            prev = c[t];
        end
    endfunction

    function automatic void add(input logic [1:0] v, input int n);
        repeat (n) seg.push_back(v);
    endfunction

    task automatic drive_seg();
        model(seg, gbase);
        foreach (seg[i]) begin
            bus.Code = seg[i];
            Reset    = 1'b1;
            @(posedge CLOCK); #2;
            gbase++;
        end
        seg.delete();
    endtask

    task automatic do_reset(input int n, input logic [1:0] code);
        Reset    = 1'b0;
        bus.Code = code;
        repeat (n) begin
            @(posedge CLOCK); #2;
        end
    endtask

    // Monitor: compares every sampled cycle against the model and consumes pulse events
    initial begin : monitor
        int   g = 0;
        logic r;
        ev_t  e;
        cyc_t c;
        forever begin
            @(posedge CLOCK);
            r = Reset;
            @(negedge CLOCK);
            if (!r) begin
                check("reset_outs", {bus.CodeOut, bus.SymValid, bus.Active, bus.LockLost}, 0);
            end else begin
                if (cycq.size() == 0) fail_now("model_underrun", g);
                else begin
                    c = cycq.pop_front();
                    check("active", bus.Active, c.act);
                    check("code_out", bus.CodeOut, c.out);
                end
                while (evq.size() > 0 && evq[0].t < g) begin
                    fail_now("missing_pulse", evq[0].t);
                    void'(evq.pop_front());
                end
                if (bus.SymValid || bus.LockLost) begin
                    if (evq.size() == 0 || evq[0].t != g) fail_now("unexpected_pulse", g);
                    else begin
                        e = evq.pop_front();
                        check("pulse_kind", {bus.SymValid, bus.LockLost}, e.kind);
                        if (bus.SymValid) obs.push_back(bus.CodeOut);
                    end
                end
                g++;
            end
        end
    end

    initial begin : driver
        logic [1:0] syms[7];
        bit         rep;
        Reset    = 1'b0;
        bus.Code = 2'b11;
        do_reset(3, 2'b11);

        // Start edge on the first cycle after release
        add(2'b11, 12);
        drive_seg();
        do_reset(1, 2'b00);

        // Acquisition, stream, lock loss and reacquisition
        syms = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b10, 2'b11, 2'b01};
        add(2'b00, 2);
        foreach (syms[i]) add(syms[i], SYM);
        add(2'b00, 16 * SYM);
        add(2'b01, SYM);
        add(2'b10, SYM);
        drive_seg();
        do_reset(1, 2'b00);

        // Reset lands on the sample edge of the second symbol
        add(2'b00, 2);
        add(2'b10, SYM);
        add(2'b01, MID);
        drive_seg();
        do_reset(1, 2'b01);
        add(2'b01, SYM);
        add(2'b00, MID);
        drive_seg();
        do_reset(1, 2'b00);

        // Drift: 9-cycle symbols alternating 01/10
        obs.delete();
        add(2'b00, 2);
        for (int i = 0; i < 20; i++) add((i % 2 == 0) ? 2'b01 : 2'b10, 9);
        drive_seg();
        do_reset(1, 2'b00);
        rep = 1'b0;
`ifdef SYNC_TRACK_EN
        for (int i = 1; i < obs.size(); i++) if (obs[i] == obs[i-1]) rep = 1'b1;
        check("drift_count", obs.size(), 20);
        check("drift_no_repeat", rep, 0);
`else
        for (int i = 1; i < 6 && i < obs.size(); i++) if (obs[i] == obs[i-1]) rep = 1'b1;
        check("drift_repeat", rep, 1);
`endif

        // Random symbols with occasional long zero runs
        for (int r = 0; r < 3; r++) begin
            add(2'b00, $urandom_range(1, 5));
            for (int s = 0; s < 40; s++) begin
                if ($urandom_range(0, 7) == 0) add(2'b00, SYM * $urandom_range(12, 18));
                else add(2'($urandom_range(0, 3)), SYM);
            end
            drive_seg();
            do_reset($urandom_range(1, 2), 2'($urandom_range(0, 3)));
        end

        @(posedge CLOCK); #2;
        check("events_drained", evq.size(), 0);
        check("cycles_drained", cycq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/viterbi_code_sync.md
# viterbi_code_sync

Symbol synchronizer between the channel/encoder output and `VITERBIDECODER`. It watches the raw `WD_CODE`-bit code stream on the fast `CLOCK` and detects the first non-zero symbol. It then samples each symbol once at mid-period and presents the result with a one-cycle strobe. It also generates the decoder's `Active` qualifier, so the testbench's combinational `Active` shim is no longer needed. Lock is dropped after a long run of all-zero symbols (idle/flush channel).

## Interface
- `WD_CODE`, 2: code symbol width; must match the decoder.
- `SYM_CYCLES`, 8: `CLOCK` cycles per code symbol; even, ≥4.
- `IDLE_SYMS`, 16: consecutive all-zero sampled symbols that cause loss of lock; ≥2.

Ports:
- `CLOCK`, in, 1: single clock; all logic on its rising edge.
- `Reset`, in, 1: reset, synchronous, active-low.
- `Code`, in, `WD_CODE`: raw code symbol, held `SYM_CYCLES` cycles per symbol.
- `CodeOut`, out, `WD_CODE`: registered mid-symbol sample.
- `SymValid`, out, 1: one-cycle pulse; `CodeOut` is new this cycle.
- `Active`, out, 1: lock indicator; feeds the decoder `Active` input.
- `LockLost`, out, 1: one-cycle pulse when lock is dropped.

## Operation
Internal registers:
- `code_q`: `Code` delayed one cycle.
- `phase`: 0..`SYM_CYCLES`-1, wraps to 0.
- `zcnt`: 0..`IDLE_SYMS`.
- Sampling point: `MID = SYM_CYCLES/2`.

States:
- IDLE
  - `phase` = 0, `zcnt` = 0.
  - An edge with `code_q`==0 and `Code`!=0 is the start edge E0: go to ALIGN, `phase` <= 1.
  - Nonzero→nonzero changes are ignored in IDLE.
- ALIGN
  - `phase` increments each cycle.
  - At the edge where `phase`==`MID`: `CodeOut` <= `Code`, `SymValid` <= 1, `Active` <= 1, `zcnt` <= 0 (the first symbol is non-zero by construction), go to LOCK.
- LOCK
  - `phase` free-runs mod `SYM_CYCLES`.
  - At each edge with `phase`==`MID`, sample `Code`:
    - `Code`!=0: `zcnt` <= 0; `CodeOut`/`SymValid` as above.
    - `Code`==0 and `zcnt`+1 < `IDLE_SYMS`: `zcnt`++; `CodeOut` <= 0, `SymValid` <= 1.
    - `Code`==0 and `zcnt`+1 == `IDLE_SYMS`: `Active` <= 0, `LockLost` <= 1, `SymValid` stays 0, `CodeOut` holds, go to IDLE.

Rules:
- `SymValid` is never asserted while `Active` is 0 after that edge.
- The `code_q` reset value is 0, so a non-zero `Code` on the first cycle after reset counts as a start edge.
- Reset mid-operation (`Reset`==0 at any edge) returns all state to reset values at that edge, regardless of state or pending sample.

## Timing
Reset values:
- State IDLE.
- `CodeOut`=0, `SymValid`=0, `Active`=0, `LockLost`=0.
- `phase`=0, `zcnt`=0, `code_q`=0.

Latency and cadence:
- Start edge E0 to first `SymValid`: `MID` cycles. `SymValid` and `CodeOut` are visible after edge E`MID`.
- Subsequent `SymValid` pulses every `SYM_CYCLES` cycles exactly (no tracking).
- `Active` rises in the same cycle as the first `SymValid`.
- `Active` falls in the same cycle as the `LockLost` pulse.
- All outputs are registered; no combinational path from `Code`.

## Configuration
- `SYNC_TRACK_EN` defined: phase tracking.
  - In LOCK, any edge with `Code`!=`code_q` forces `phase` <= 1, re-centring sampling `MID` cycles after each transition.
  - If a transition coincides with `phase`==`MID`, the sample is still taken (new `Code` value), then `phase` <= 1.
  - Zero runs produce no transitions, so `phase` free-runs through them.
- `SYNC_TRACK_EN` undefined: `phase` is never reloaded in LOCK; pure free-running symbol timer.

## Test plan
- Reset:
  - Stimulus: `Reset`=0 for 3 cycles with `Code`=2'b11.
  - Required: `Active`=0, `SymValid`=0, `CodeOut`=00, `LockLost`=0 throughout; a start edge is seen on the first cycle after release.
- Acquisition:
  - Stimulus: `Code` 00 then 11 at edge E0, held 8 cycles.
  - Required: `SymValid`=1 and `CodeOut`=11 at E4; `Active`=1 from E4; next `SymValid` at E12.
- Stream:
  - Stimulus: 11,10,11,00,10,11,01 with 8 cycles each.
  - Required: exactly 7 `SymValid` pulses, with `CodeOut` in that order; `Active` stays 1.
- Lock loss:
  - Stimulus: after lock, 16 zero symbols.
  - Required: 15 `SymValid` pulses with 00; at the 16th sample, `Active`→0, `LockLost` pulses one cycle, no `SymValid`.
  - Follow-up stimulus: 00→01. Required: reacquire with first `SymValid` 4 cycles later.
- Reset mid-lock:
  - Stimulus: `Reset`=0 for one cycle at `phase`==`MID`.
  - Required: no `SymValid`; all outputs at reset values next cycle; state IDLE.
- Drift (`Code` period 9 cycles, alternating 01/10):
  - With `SYNC_TRACK_EN`: every symbol output exactly once over 20 symbols.
  - Without: at least one symbol repeated within the first 6 samples.
